// File: rtl/othello_task_scheduler_if.sv
// Upstream solve-task stream (player/opponent bitboards plus task id) with valid/ready handshake.
interface othello_task_scheduler_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_player;
    logic [63:0] in_opponent;
    logic [15:0] in_taskid;

    modport master (output in_valid, in_player, in_opponent, in_taskid, input in_ready);
    modport slave  (input in_valid, in_player, in_opponent, in_taskid, output in_ready);
endinterface

// File: rtl/othello_task_scheduler.sv
// Keeps the Othello endgame pipeline slots full: fill burst, refill on solved, idle-board injection,
// result forwarding, and in-flight tracking so that a stop drains cleanly.
module othello_task_scheduler #(
    parameter int          FILL_LEN = 9,
    parameter logic [15:0] IDLE_ID  = 16'hffff,
    parameter int          CNT_W    = 4
) (
    input  logic                    iCLOCK,
    input  logic                    iRESET,
    input  logic                    start,
    input  logic                    stop,
    othello_task_scheduler_if.slave up,
    output logic                    enable,
    output logic                    valid,
    output logic [63:0]             iPlayer,
    output logic [63:0]             iOpponent,
    output logic [15:0]             iTaskid,
    input  logic                    solved,
    input  logic [15:0]             oTaskid,
    input  logic signed [7:0]       res,
    output logic                    res_valid,
    output logic [15:0]             res_taskid,
    output logic signed [7:0]       res_value,
    output logic [CNT_W-1:0]        inflight,
    output logic [31:0]             solved_count,
    output logic                    busy,
    output logic                    done,
    output logic                    err_idle_id
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [63:0] player;
        logic [63:0] opponent;
        logic [15:0] taskid;
    } boardTask_t;

    localparam boardTask_t IDLE_TASK = '{player: {64{1'b1}}, opponent: 64'd0, taskid: IDLE_ID};
    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(FILL_LEN);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LEN - 1);

    state_t           state, nextState;
    logic [CNT_W-1:0] fillCnt;
    logic             fillPending;
    logic             loadEvent, acceptOk;
    logic             realIn, badIn, realRes;
    boardTask_t       pres;

    // fillCnt == FILL_MAX means no burst loads are outstanding
    assign fillPending = (fillCnt != FILL_MAX);

    assign up.in_ready = loadEvent & acceptOk;
    assign realIn      = up.in_ready & up.in_valid & (up.in_taskid != IDLE_ID);
    assign badIn       = up.in_ready & up.in_valid & (up.in_taskid == IDLE_ID);
    assign realRes     = solved & (oTaskid != IDLE_ID);

    assign iPlayer   = pres.player;
    assign iOpponent = pres.opponent;
    assign iTaskid   = pres.taskid;

    always_ff @(posedge iCLOCK) begin
        if (iRESET) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start) nextState = FILL;
            FILL:    if (stop) nextState = DRAIN;
                     else if (fillCnt == FILL_LAST) nextState = RUN;
            RUN:     if (stop) nextState = DRAIN;
            DRAIN:   if (inflight == '0) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        enable    = busy;
        valid     = busy;
        loadEvent = 1'b0;
        acceptOk  = 1'b0;
        unique case (state)
            FILL:  begin loadEvent = 1'b1;   acceptOk = 1'b1; end
            RUN:   begin loadEvent = solved; acceptOk = 1'b1; end
            // a stop during the burst still issues the remaining burst loads, as idle boards
            DRAIN: loadEvent = solved | fillPending;
            default: ;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET)                                fillCnt <= FILL_MAX;
        else if (state == IDLE && start)           fillCnt <= '0;
        else if (state == DRAIN && nextState == IDLE) fillCnt <= FILL_MAX;
        else if ((state == FILL || state == DRAIN) && fillPending)
            fillCnt <= fillCnt + CNT_W'(1);
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            pres         <= IDLE_TASK;
            res_valid    <= 1'b0;
            res_taskid   <= IDLE_ID;
            res_value    <= '0;
            solved_count <= '0;
            inflight     <= '0;
            err_idle_id  <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (loadEvent)
                pres <= realIn ? '{player: up.in_player, opponent: up.in_opponent, taskid: up.in_taskid}
                               : IDLE_TASK;
            res_valid <= realRes;
            if (realRes) begin
                res_taskid   <= oTaskid;
                res_value    <= res;
                solved_count <= solved_count + 32'd1;
            end
            unique case ({realIn, realRes})
                2'b10:   if (inflight != FILL_MAX) inflight <= inflight + CNT_W'(1);
                2'b01:   if (inflight != '0)       inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
            if (badIn) err_idle_id <= 1'b1;
            done <= (state == DRAIN) && (nextState == IDLE);
        end
    end
endmodule

// File: tb/tb_othello_task_scheduler.sv
// Directed and randomized bench for othello_task_scheduler against a rule-level reference model.
module tb_othello_task_scheduler;
  localparam int          FL  = 9;
  localparam logic [15:0] IDL = 16'hffff;
  localparam bit          Y   = 1'b1;
  localparam bit          N   = 1'b0;
  localparam int MI = 0, MF = 1, MR = 2, MD = 3;

  typedef struct { logic [63:0] p; logic [63:0] o; logic [15:0] id; } tk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, solved;
  logic [15:0] oTaskid;
  logic signed [7:0] res;
  logic enable, valid, res_valid, busy, done, err;
  logic [63:0] iP, iO;
  logic [15:0] iT, resId;
  logic signed [7:0] resVal;
  logic [3:0] inflight;
  logic [31:0] cnt;

  othello_task_scheduler_if up();

  othello_task_scheduler dut (
    .iCLOCK(clk), .iRESET(rst), .start(start), .stop(stop), .up(up),
    .enable(enable), .valid(valid), .iPlayer(iP), .iOpponent(iO), .iTaskid(iT),
    .solved(solved), .oTaskid(oTaskid), .res(res),
    .res_valid(res_valid), .res_taskid(resId), .res_value(resVal),
    .inflight(inflight), .solved_count(cnt), .busy(busy), .done(done), .err_idle_id(err)
  );

  int total = 0, bad = 0, nextId = 0;
  tk_t upq[$];
  logic [15:0] pipeIds[$];

  int mMode, mFill, mInfl;
  logic [31:0] mCnt;
  bit mErr, mResV, mDone;
  logic [15:0] mResId;
  logic [7:0] mResVal;
  tk_t mPres;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode = MI; mFill = 0; mInfl = 0; mCnt = 0; mErr = 0; mResV = 0; mDone = 0;
    mResId = IDL; mResVal = 8'd0;
    mPres = '{p: {64{1'b1}}, o: 64'd0, id: IDL};
    pipeIds.delete();
  endtask

  task automatic addTasks(input int n);
    for (int i = 0; i < n; i++) begin
      upq.push_back('{p: {$urandom, $urandom}, o: {$urandom, $urandom}, id: 16'(nextId)});
      nextId++;
    end
  endtask

  function automatic logic [15:0] pickOid();
    if (pipeIds.size() > 0 && $urandom_range(0, 3) != 0)
      return pipeIds[$urandom_range(0, pipeIds.size() - 1)];
    return IDL;
  endfunction

  // One clock: drive inputs, check the combinational ready, advance the model, check registers.
  task automatic cycle(input bit r, input bit st, input bit sp, input bit offer,
                       input bit sv, input logic [15:0] oid, input logic [7:0] rv);
    bit ld, rdy, acc, realIn, realRes, inV;
    int oldInfl, idx[$];
    tk_t h;
    h = '{p: {$urandom, $urandom}, o: {$urandom, $urandom}, id: 16'($urandom)};
    inV = offer && upq.size() > 0;
    if (inV) h = upq[0];
    rst = r; start = st; stop = sp; solved = sv; oTaskid = oid; res = rv;
    up.in_valid = inV; up.in_player = h.p; up.in_opponent = h.o; up.in_taskid = h.id;
    #1;
    ld  = (mMode == MF) || ((mMode == MR || mMode == MD) && sv) || (mMode == MD && mFill > 0);
    rdy = ld && (mMode == MF || mMode == MR);
    chk("in_ready", 64'(up.in_ready), 64'(rdy));
    @(posedge clk);
    if (r) begin
      modelReset();
      upq.delete();
    end else begin
      acc = rdy && inV;
      realIn = acc && h.id != IDL;
      if (acc) void'(upq.pop_front());
      if (realIn) pipeIds.push_back(h.id);
      if (acc && h.id == IDL) mErr = 1;
      if (ld) mPres = realIn ? h : '{p: {64{1'b1}}, o: 64'd0, id: IDL};
      realRes = sv && oid != IDL;
      mResV = realRes;
      if (realRes) begin
        mResId = oid; mResVal = rv; mCnt++;
        idx = pipeIds.find_first_index(x) with (x == oid);
        if (idx.size() > 0) pipeIds.delete(idx[0]);
      end
      oldInfl = mInfl;
      if (realIn && !realRes && mInfl < FL) mInfl++;
      else if (!realIn && realRes && mInfl > 0) mInfl--;
      mDone = 0;
      case (mMode)
        MI: if (st) begin mMode = MF; mFill = FL; end
        MF: begin
          mFill--;
          if (sp) mMode = MD;
          else if (mFill == 0) mMode = MR;
        end
        MR: if (sp) mMode = MD;
        default: begin
          if (mFill > 0) mFill--;
          if (oldInfl == 0) begin mMode = MI; mDone = 1; mFill = 0; end
        end
      endcase
    end
    #1;
    chk("iTaskid", 64'(iT), 64'(mPres.id));
    chk("iPlayer", iP, mPres.p);
    chk("iOpponent", iO, mPres.o);
    chk("enable", 64'(enable), 64'(mMode != MI));
    chk("valid", 64'(valid), 64'(mMode != MI));
    chk("busy", 64'(busy), 64'(mMode != MI));
    chk("res_valid", 64'(res_valid), 64'(mResV));
    chk("res_taskid", 64'(resId), 64'(mResId));
    chk("res_value", 64'($unsigned(resVal)), 64'(mResVal));
    chk("inflight", 64'(inflight), 64'(mInfl));
    chk("solved_count", 64'(cnt), 64'(mCnt));
    chk("done", 64'(done), 64'(mDone));
    chk("err_idle_id", 64'(err), 64'(mErr));
  endtask

  task automatic idleCyc(input bit offer);
    cycle(N, N, N, offer, N, IDL, 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; solved = 1'b0; oTaskid = IDL; res = 8'sd0;
    up.in_valid = 1'b0; up.in_player = 64'd0; up.in_opponent = 64'd0; up.in_taskid = 16'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    cycle(Y, N, N, N, N, IDL, 8'd0);
    chk("rst.iTaskid", 64'(iT), 64'hffff);
    chk("rst.iPlayer", iP, 64'hffffffffffffffff);
    chk("rst.iOpponent", iO, 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.res_taskid", 64'(resId), 64'hffff);

    // fill burst with ids 0..19 queued
    addTasks(20);
    cycle(N, Y, N, Y, N, IDL, 8'd0);
    for (int i = 0; i < FL; i++) begin
      idleCyc(Y);
      chk("fill.id", 64'(iT), 64'(i));
    end
    chk("fill.inflight", 64'(inflight), 64'd9);
    idleCyc(Y);
    chk("run.hold", 64'(iT), 64'd8);

    cycle(N, N, N, Y, Y, 16'd3, 8'hf4);
    chk("refill.id", 64'(iT), 64'd9);
    chk("refill.res_valid", 64'(res_valid), 64'd1);
    chk("refill.res_taskid", 64'(resId), 64'd3);
    chk("refill.res_value", 64'($unsigned(resVal)), 64'hf4);
    chk("refill.inflight", 64'(inflight), 64'd9);
    idleCyc(Y);
    chk("refill.pulse", 64'(res_valid), 64'd0);

    cycle(N, N, N, N, Y, 16'd5, 8'd7);
    chk("starve.id", 64'(iT), 64'hffff);
    chk("starve.inflight", 64'(inflight), 64'd8);
    cycle(N, N, N, Y, Y, IDL, 8'd0);
    chk("idlesolve.res_valid", 64'(res_valid), 64'd0);
    chk("idlesolve.inflight", 64'(inflight), 64'd9);

    // randomized run traffic, including refills that would overflow the counter
    for (int i = 0; i < 300; i++) begin
      bit sv;
      if (upq.size() < 4) addTasks(8);
      sv = ($urandom_range(0, 2) == 0);
      cycle(N, $urandom_range(0, 15) == 0, N, $urandom_range(0, 3) != 0, sv, pickOid(), 8'($urandom));
    end

    // reset in the middle of RUN
    cycle(Y, N, N, N, N, IDL, 8'd0);
    addTasks(12);
    cycle(N, Y, N, Y, N, IDL, 8'd0);
    for (int i = 0; i < FL; i++) idleCyc(Y);
    for (int i = 0; i < 3; i++) cycle(N, N, N, N, Y, pipeIds[0], 8'($urandom));
    chk("midrst.pre_inflight", 64'(inflight), 64'd6);
    cycle(Y, N, N, Y, N, IDL, 8'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.inflight", 64'(inflight), 64'd0);
    chk("midrst.count", 64'(cnt), 64'd0);
    chk("midrst.iTaskid", 64'(iT), 64'hffff);

    // a real result while nothing is in flight must not underflow
    cycle(N, N, N, N, Y, 16'd7, 8'd5);
    chk("sat.res_valid", 64'(res_valid), 64'd1);
    chk("sat.inflight", 64'(inflight), 64'd0);

    // drain from RUN with a full pipeline
    cycle(Y, N, N, N, N, IDL, 8'd0);
    addTasks(12);
    cycle(N, Y, N, Y, N, IDL, 8'd0);
    for (int i = 0; i < FL; i++) idleCyc(Y);
    cycle(N, N, Y, Y, N, IDL, 8'd0);
    chk("drain.busy", 64'(busy), 64'd1);
    for (int i = 0; i < FL; i++) begin
      cycle(N, N, N, Y, Y, pipeIds[0], 8'($urandom));
      chk("drain.ready", 64'(up.in_ready), 64'd0);
      chk("drain.id", 64'(iT), 64'hffff);
    end
    chk("drain.inflight", 64'(inflight), 64'd0);
    idleCyc(Y);
    chk("drain.done", 64'(done), 64'd1);
    chk("drain.enable", 64'(enable), 64'd0);
    chk("drain.count", 64'(cnt), 64'd9);
    idleCyc(Y);
    chk("drain.done_pulse", 64'(done), 64'd0);

    // idle id offered during fill
    cycle(Y, N, N, N, N, IDL, 8'd0);
    addTasks(2);
    upq.push_back('{p: 64'h1234, o: 64'h5678, id: IDL});
    addTasks(10);
    cycle(N, Y, N, Y, N, IDL, 8'd0);
    idleCyc(Y);
    idleCyc(Y);
    idleCyc(Y);
    chk("badid.id", 64'(iT), 64'hffff);
    chk("badid.err", 64'(err), 64'd1);
    for (int i = 0; i < FL - 3; i++) idleCyc(Y);
    chk("badid.inflight", 64'(inflight), 64'd8);
    for (int i = 0; i < 5; i++) cycle(N, N, N, Y, Y, pickOid(), 8'($urandom));
    chk("badid.sticky", 64'(err), 64'd1);

    // stop in the middle of the fill burst, then drain
    cycle(Y, N, N, N, N, IDL, 8'd0);
    addTasks(12);
    cycle(N, Y, N, Y, N, IDL, 8'd0);
    for (int i = 0; i < 3; i++) idleCyc(Y);
    cycle(N, N, Y, Y, N, IDL, 8'd0);
    chk("fillstop.inflight", 64'(inflight), 64'd4);
    idleCyc(Y);
    chk("fillstop.id", 64'(iT), 64'hffff);
    for (int i = 0; i < 40 && mMode != MI; i++) begin
      if (pipeIds.size() > 0 && i % 2 == 1) cycle(N, N, N, Y, Y, pipeIds[0], 8'($urandom));
      else idleCyc(Y);
    end
    chk("fillstop.idle", 64'(busy), 64'd0);
    chk("fillstop.inflight_end", 64'(inflight), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
